// File: rtl/nand_tt_pkg.sv
// Shared types and helpers for the NAND truth-table tester.
package nand_tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Truth-table vectors, ordered {in1,in2}
  localparam logic [1:0] V00 = 2'b00;
  localparam logic [1:0] V01 = 2'b01;
  localparam logic [1:0] V10 = 2'b10;
  localparam logic [1:0] V11 = 2'b11;

  // Ideal NAND response for a vector
  function automatic logic nand_exp(input logic [1:0] vec);
    return ~(vec[1] & vec[0]);
  endfunction

endpackage

// File: rtl/nand_tt_tester_if.sv
// Control/status bundle of the NAND truth-table tester.
// master = controller issuing runs, slave = the tester itself.
interface nand_tt_tester_if #(
  parameter int ERR_W  = 8,
  parameter int LOOP_W = 8
) ();

  logic              start;
  logic              abort;
  logic [LOOP_W-1:0] loops;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_cnt;
  logic [1:0]        last_fail_vec;
  logic [ERR_W-1:0]  glitch_cnt;

  modport master (
    output start, abort, loops,
    input  busy, done, pass, err_cnt, last_fail_vec, glitch_cnt
  );

  modport slave (
    input  start, abort, loops,
    output busy, done, pass, err_cnt, last_fail_vec, glitch_cnt
  );

endinterface

// File: rtl/nand_tt_sync.sv
// Two-flop synchroniser for the asynchronous NAND cell output.
// Resets to 1, the value an idle NAND (inputs 00) drives.
module nand_tt_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of d into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nand_tt_tester.sv
// Truth-table stimulus and checker around a 2-input NAND cell.
// Steps {in1,in2} through 00,01,10,11 (DWELL cycles each), samples the
// synchronised cell output at dwell index SETTLE and counts mismatches.
// Optional feature: define NAND_TT_GLITCH_MON_EN to build the glitch
// monitor that counts output toggles in the stable part of each dwell.
import nand_tt_pkg::*;

module nand_tt_tester #(
  parameter int DWELL  = 16,
  parameter int SETTLE = 4,
  parameter int ERR_W  = 8,
  parameter int LOOP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dut_out,
  output logic             in1,
  output logic             in2,
  nand_tt_tester_if.slave  ctl
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]        state;
  logic [1:0]        vec;
  logic [DW_W-1:0]   dwell_cnt;
  logic [LOOP_W-1:0] loop_cnt;
  logic [LOOP_W-1:0] loops_q;
  logic [ERR_W-1:0]  err_cnt;
  logic [1:0]        last_fail_vec;
  logic              pass_q;
  logic              sync_q;

  logic dwell_end;
  logic sample;
  logic mismatch;
  logic last_pass;
  logic run_end;
  logic accept;

  nand_tt_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_out),
    .q     (sync_q)
  );

  assign accept    = (state == S_IDLE) && ctl.start && !ctl.abort;
  assign dwell_end = (dwell_cnt == DW_W'(DWELL - 1));
  assign sample    = (state == S_RUN) && (dwell_cnt == DW_W'(SETTLE));
  assign mismatch  = sample && (sync_q != nand_exp(vec));
  // loops_q==0 means run until aborted, so it never terminates a run
  assign last_pass = (loops_q != '0) && ((loop_cnt + LOOP_W'(1)) == loops_q);
  assign run_end   = (state == S_RUN) && dwell_end && (vec == V11) && last_pass;

  // Sequencer: state, current vector, dwell and pass counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      vec       <= V00;
      dwell_cnt <= '0;
      loop_cnt  <= '0;
      loops_q   <= '0;
    end else if (ctl.abort) begin
      state     <= S_IDLE;
      vec       <= V00;
      dwell_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctl.start) begin
            state     <= S_RUN;
            vec       <= V00;
            dwell_cnt <= '0;
            loop_cnt  <= '0;
            loops_q   <= ctl.loops;
          end
        end
        S_RUN: begin
          if (dwell_end) begin
            dwell_cnt <= '0;
            if (run_end) begin
              // vector 11 stays on the pins through the DONE cycle
              state <= S_DONE;
            end else begin
              vec <= vec + 2'd1;
              if (vec == V11) loop_cnt <= loop_cnt + LOOP_W'(1);
            end
          end else begin
            dwell_cnt <= dwell_cnt + DW_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          vec   <= V00;
        end
        default: begin
          state <= S_IDLE;
          vec   <= V00;
        end
      endcase
    end
  end

  // Result tracking: saturating error count, last failing vector, pass flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt       <= '0;
      last_fail_vec <= V00;
      pass_q        <= 1'b0;
    end else if (ctl.abort) begin
      pass_q <= 1'b0;
    end else if (accept) begin
      err_cnt       <= '0;
      last_fail_vec <= V00;
      pass_q        <= 1'b0;
    end else begin
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
        last_fail_vec <= vec;
      end
      // sampling never coincides with the last dwell cycle, so err_cnt is final here
      if (run_end) pass_q <= (err_cnt == '0);
    end
  end

`ifdef NAND_TT_GLITCH_MON_EN
  logic             sync_d;
  logic [ERR_W-1:0] glitch_cnt;
  logic             in_window;

  assign in_window = (state == S_RUN) && (dwell_cnt > DW_W'(SETTLE));

  // Count output toggles once the cell should have settled for this vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d     <= 1'b1;
      glitch_cnt <= '0;
    end else begin
      sync_d <= sync_q;
      if (accept)
        glitch_cnt <= '0;
      else if (in_window && (sync_q != sync_d) && (glitch_cnt != '1))
        glitch_cnt <= glitch_cnt + ERR_W'(1);
    end
  end

  assign ctl.glitch_cnt = glitch_cnt;
`else
  assign ctl.glitch_cnt = '0;
`endif

  assign {in1, in2}        = vec;
  assign ctl.busy          = (state == S_RUN);
  assign ctl.done          = (state == S_DONE);
  assign ctl.pass          = pass_q;
  assign ctl.err_cnt       = err_cnt;
  assign ctl.last_fail_vec = last_fail_vec;

endmodule

// File: tb/tb_nand_tt_tester.sv
// Directed bench for nand_tt_tester: table-driven truth-table walk plus
// hand-written sequences for stuck outputs, saturation, abort, restart,
// asynchronous reset and the optional glitch monitor.
module tb_nand_tt_tester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nand_tt_tester_if #(.ERR_W(8), .LOOP_W(8)) ctl ();
  nand_tt_tester_if #(.ERR_W(2), .LOOP_W(8)) ctl2 ();

  logic in1, in2, dut_out;
  logic in1b, in2b;
  logic stuck0 = 1'b0;
  int   mode;     // 0 ideal NAND (+glitch), 1 stuck at 1, 2 stuck at 0
  logic glitch;

  // NAND cell model driven from the tester pins
  always_comb begin
    dut_out = ~(in1 & in2) ^ glitch;
    if (mode == 1) dut_out = 1'b1;
    else if (mode == 2) dut_out = 1'b0;
  end

  nand_tt_tester #(.DWELL(16), .SETTLE(4), .ERR_W(8), .LOOP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .dut_out(dut_out), .in1(in1), .in2(in2), .ctl(ctl)
  );

  nand_tt_tester #(.DWELL(16), .SETTLE(4), .ERR_W(2), .LOOP_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .dut_out(stuck0), .in1(in1b), .in2(in2b), .ctl(ctl2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_seen = 0;

  always @(negedge clk) if (ctl.done === 1'b1) done_seen++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // start is sampled at the next edge; afterwards we sit in cycle 1 of the run
  task automatic do_start(input int lp);
    ctl.loops = 8'(lp);
    ctl.start = 1'b1;
    @(posedge clk);
    #1;
    ctl.start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ctl.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [1:0] vec;
    logic       busy;
    logic       done;
    logic       pass;
  } tt_rec_t;

  tt_rec_t tbl[10];

  initial begin
    bit ok;
    int k;
    int ds0;
    logic [7:0] exp_glitch;

    tbl[0] = '{1,  2'b00, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{16, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{17, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{32, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{33, 2'b10, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{48, 2'b10, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{49, 2'b11, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{64, 2'b11, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{65, 2'b11, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{66, 2'b00, 1'b0, 1'b0, 1'b1};

    ctl.start = 1'b0;  ctl.abort = 1'b0;  ctl.loops = '0;
    ctl2.start = 1'b0; ctl2.abort = 1'b0; ctl2.loops = '0;
    mode = 0;
    glitch = 1'b0;

    // Reset state
    step(3);
    check("rst_vec", {in1, in2}, 2'b00);
    check("rst_busy", ctl.busy, 1'b0);
    check("rst_done", ctl.done, 1'b0);
    check("rst_pass", ctl.pass, 1'b0);
    check("rst_err", ctl.err_cnt, 8'd0);
    check("rst_lfv", ctl.last_fail_vec, 2'b00);
    check("rst_glitch", ctl.glitch_cnt, 8'd0);
    rst_n = 1'b1;
    step(2);

    // 1: ideal NAND, loops=1, table-driven walk through the run
    do_start(1);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].cyc - cyc);
      check($sformatf("t1_vec@%0d", tbl[i].cyc), {in1, in2}, tbl[i].vec);
      check($sformatf("t1_busy@%0d", tbl[i].cyc), ctl.busy, tbl[i].busy);
      check($sformatf("t1_done@%0d", tbl[i].cyc), ctl.done, tbl[i].done);
      check($sformatf("t1_pass@%0d", tbl[i].cyc), ctl.pass, tbl[i].pass);
    end
    check("t1_err", ctl.err_cnt, 8'd0);
    check("t1_done_pulses", done_seen, 1);
    step(2);

    // 2: stuck at 1, loops=2 -> vector 11 fails once per pass
    mode = 1;
    do_start(2);
    wait_done(300, ok);
    check("t2_done_seen", ok, 1'b1);
    check("t2_done_cycle", cyc, 129);
    check("t2_err", ctl.err_cnt, 8'd2);
    check("t2_lfv", ctl.last_fail_vec, 2'b11);
    check("t2_pass", ctl.pass, 1'b0);
    step(1);
    check("t2_done_1cyc", ctl.done, 1'b0);
    check("t2_pass_held", ctl.pass, 1'b0);

    // 3: stuck at 0 on the 2-bit counter instance, loops=3 -> saturates
    ctl2.loops = 8'd3;
    ctl2.start = 1'b1;
    step(1);
    ctl2.start = 1'b0;
    k = 1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (ctl2.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step(1);
      k++;
    end
    check("t3_done_seen", ok, 1'b1);
    check("t3_done_cycle", k, 193);
    check("t3_err_sat", ctl2.err_cnt, 2'd3);
    check("t3_lfv", ctl2.last_fail_vec, 2'b10);
    check("t3_pass", ctl2.pass, 1'b0);
    step(2);

    // 4: loops=0 runs until abort at cycle 200
    mode = 1;
    ds0 = done_seen;
    do_start(0);
    step(199);
    check("t4_busy_before", ctl.busy, 1'b1);
    ctl.abort = 1'b1;
    step(1);
    ctl.abort = 1'b0;
    check("t4_busy_after", ctl.busy, 1'b0);
    check("t4_vec_after", {in1, in2}, 2'b00);
    check("t4_err_held", ctl.err_cnt, 8'd3);
    check("t4_lfv_held", ctl.last_fail_vec, 2'b11);
    step(5);
    check("t4_pass", ctl.pass, 1'b0);
    check("t4_err_still", ctl.err_cnt, 8'd3);
    check("t4_no_done", done_seen, ds0);
    // start and abort together in IDLE: start is dropped
    ctl.loops = 8'd1;
    ctl.start = 1'b1;
    ctl.abort = 1'b1;
    step(1);
    ctl.start = 1'b0;
    ctl.abort = 1'b0;
    step(1);
    check("t4_startabort_busy", ctl.busy, 1'b0);
    check("t4_startabort_err", ctl.err_cnt, 8'd3);

    // 5: start mid-run ignored, then async reset at cycle 30
    mode = 2;
    do_start(1);
    step(19);
    ctl.start = 1'b1;
    step(1);
    ctl.start = 1'b0;
    check("t5_vec21", {in1, in2}, 2'b01);
    check("t5_busy21", ctl.busy, 1'b1);
    step(9);
    check("t5_vec30", {in1, in2}, 2'b01);
    check("t5_err30", ctl.err_cnt, 8'd2);
    check("t5_lfv30", ctl.last_fail_vec, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", ctl.busy, 1'b0);
    check("t5_rst_vec", {in1, in2}, 2'b00);
    check("t5_rst_err", ctl.err_cnt, 8'd0);
    check("t5_rst_lfv", ctl.last_fail_vec, 2'b00);
    step(2);
    rst_n = 1'b1;
    step(2);

    // 6: 3-cycle pulse on the output at dwell 10 of vector 01
    mode = 0;
    do_start(1);
    step(26);
    glitch = 1'b1;
    step(3);
    glitch = 1'b0;
    wait_done(100, ok);
    check("t6_done_seen", ok, 1'b1);
    check("t6_done_cycle", cyc, 65);
    check("t6_err", ctl.err_cnt, 8'd0);
    check("t6_pass", ctl.pass, 1'b1);
`ifdef NAND_TT_GLITCH_MON_EN
    exp_glitch = 8'd2;
`else
    exp_glitch = 8'd0;
`endif
    check("t6_glitch", ctl.glitch_cnt, exp_glitch);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
